// File: rtl/fetch_byte_sequencer_if.sv
// rtl/fetch_byte_sequencer_if.sv - byte-wide instruction memory read bus
// Purpose: groups the request/acknowledge memory read handshake.
// Signals:
//   mem_req   master->slave  read request
//   mem_addr  master->slave  64-bit byte address, stable until mem_ack
//   mem_ack   slave->master  mem_rdata valid this cycle
//   mem_rdata slave->master  returned byte
interface fetch_byte_sequencer_if;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/fetch_byte_sequencer.sv
// rtl/fetch_byte_sequencer.sv - instruction byte fetch sequencer
// Purpose: reads up to MaxBytes bytes from byte-wide instruction memory
//   starting at PC and assembles them big-endian onto Instruction.
// Optional build macro: LEN_DECODE_EN (length decode from icode, ADR on
//   a required byte beyond memory instead of zero padding).
// Ports:
//   Clk, Rst        clock, synchronous active-high reset
//   start, PC       begin fetch at PC (IDLE, or DONE with consume)
//   consume         Fetch has taken Instruction
//   mem             memory read bus (master side)
//   Instruction     byte i at bits [8i:8i+7]
//   instr_valid     Instruction complete and stable
//   busy            fetch in progress
//   ADR             sticky instruction-address error
module fetch_byte_sequencer #(
    parameter int MemSize  = 1024,
    parameter int MaxBytes = 10
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          start,
    input  logic [63:0]                   PC,
    input  logic                          consume,
    fetch_byte_sequencer_if.master        mem,
    output logic [0:79]                   Instruction,
    output logic                          instr_valid,
    output logic                          busy,
    output logic                          ADR
);
    localparam logic [63:0] MEM_SIZE = 64'(MemSize);
    localparam logic [3:0]  MAX_NEED = 4'(MaxBytes);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic [63:0] r_base;
    logic [0:79] r_instr;

    logic        w_accept;
    logic        w_capture;
    logic [3:0]  w_need;
    logic [3:0]  w_cnt_inc;
    logic [64:0] w_next_addr;
    logic        w_next_oob;

`ifdef LEN_DECODE_EN
    logic [3:0]  r_need;

    function automatic logic [3:0] len_of(input logic [3:0] icode);
        case (icode)
            4'h0, 4'h1, 4'h9:       len_of = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: len_of = 4'd2;
            4'h7, 4'h8:             len_of = 4'd9;
            4'h3, 4'h4, 4'h5:       len_of = 4'd10;
            default:                len_of = 4'd1;
        endcase
    endfunction
`endif

    // Address of the byte after the current one; carry out of bit 63 means
    // the address wrapped and is treated as beyond memory.
    assign w_next_addr = {1'b0, r_base} + {61'd0, r_cnt} + 65'd1;
    assign w_next_oob  = w_next_addr[64] || (w_next_addr[63:0] >= MEM_SIZE);
    assign w_cnt_inc   = r_cnt + 4'd1;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
`ifdef LEN_DECODE_EN
        // Length is known once byte 0 arrives; later bytes use the latched value.
        w_need = (r_cnt == 4'd0) ? len_of(mem.mem_rdata[7:4]) : r_need;
`else
        w_need = MAX_NEED;
`endif
        case (r_state)
            IDLE: w_accept = start;
            REQ: begin
                if (mem.mem_ack) begin
                    w_capture = 1'b1;
                    if (w_cnt_inc == w_need) begin
                        w_state_next = DONE;
                    end else if (w_next_oob) begin
`ifdef LEN_DECODE_EN
                        w_state_next = ERR;
`else
                        w_state_next = DONE;
`endif
                    end
                end
            end
            DONE: begin
                if (consume) begin
                    if (start) w_accept = 1'b1;
                    else       w_state_next = IDLE;
                end
            end
            default: w_state_next = ERR;
        endcase
        if (w_accept) begin
            w_state_next = (PC >= MEM_SIZE) ? ERR : REQ;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cnt   <= 4'd0;
            r_base  <= 64'd0;
            r_instr <= '0;
`ifdef LEN_DECODE_EN
            r_need  <= MAX_NEED;
`endif
        end else if (w_accept) begin
            r_cnt   <= 4'd0;
            r_base  <= PC;
            r_instr <= '0;
`ifdef LEN_DECODE_EN
            r_need  <= MAX_NEED;
`endif
        end else if (w_capture) begin
            r_instr[{r_cnt, 3'b000} +: 8] <= mem.mem_rdata;
            r_cnt   <= w_cnt_inc;
`ifdef LEN_DECODE_EN
            r_need  <= w_need;
`endif
        end
    end

    assign mem.mem_req  = (r_state == REQ);
    assign mem.mem_addr = r_base + {60'd0, r_cnt};
    assign Instruction  = r_instr;
    assign instr_valid  = (r_state == DONE);
    assign busy         = (r_state == REQ);
    assign ADR          = (r_state == ERR);
endmodule

// File: tb/tb_fetch_byte_sequencer.sv
// tb/tb_fetch_byte_sequencer.sv - directed bench for fetch_byte_sequencer
module tb_fetch_byte_sequencer;
    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] PC = 64'd0;
    logic        consume = 1'b0;
    logic [0:79] Instruction;
    logic        instr_valid;
    logic        busy;
    logic        ADR;

    fetch_byte_sequencer_if bus ();

    fetch_byte_sequencer dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .start       (start),
        .PC          (PC),
        .consume     (consume),
        .mem         (bus),
        .Instruction (Instruction),
        .instr_valid (instr_valid),
        .busy        (busy),
        .ADR         (ADR)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem_bytes [0:1023];
    logic [63:0] addr_log [$];
    int          ack_delay = 0;
    int          req_cycles = 0;
    logic        ack_force = 1'b0;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory responder: acks on the (ack_delay+1)th cycle of each request.
    initial begin
        int          wcnt;
        logic [63:0] held;
        wcnt = 0;
        held = 64'd0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        forever begin
            @(negedge Clk);
            if (ack_force) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 8'hAA;
            end else if (!bus.mem_req) begin
                bus.mem_ack = 1'b0;
                wcnt = 0;
            end else begin
                req_cycles++;
                if (wcnt == 0) held = bus.mem_addr;
                else check("addr_hold", {16'd0, bus.mem_addr}, {16'd0, held});
                if (wcnt == ack_delay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem_bytes[bus.mem_addr[9:0]];
                    addr_log.push_back(bus.mem_addr);
                    wcnt = 0;
                end else begin
                    bus.mem_ack = 1'b0;
                    wcnt++;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b1;
        start = 1'b0;
        consume = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic launch(input logic [63:0] pc);
        @(negedge Clk);
        addr_log.delete();
        start = 1'b1;
        PC = pc;
        @(posedge Clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (n < 200) begin
            @(posedge Clk);
            #1;
            n++;
            if (instr_valid) break;
        end
        if (!instr_valid) check("valid_timeout", {79'd0, instr_valid}, 80'd1);
    endtask

    task automatic consume_it();
        @(negedge Clk);
        consume = 1'b1;
        @(posedge Clk);
        #1;
        consume = 1'b0;
        check("consume_idle", {79'd0, instr_valid}, 80'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 1024; i++) mem_bytes[i] = 8'h00;
        mem_bytes[0] = 8'h30;
        mem_bytes[1] = 8'hF2;
        mem_bytes[2] = 8'h0A;
`ifdef LEN_DECODE_EN
        mem_bytes[1020] = 8'h30;
`else
        mem_bytes[1020] = 8'h11;
`endif
        mem_bytes[1021] = 8'h22;
        mem_bytes[1022] = 8'h33;
        mem_bytes[1023] = 8'h44;
        mem_bytes[500]  = 8'h90;

        do_reset();
        #1;
        check("rst_req",   {79'd0, bus.mem_req}, 80'd0);
        check("rst_addr",  {16'd0, bus.mem_addr}, 80'd0);
        check("rst_instr", Instruction, 80'd0);
        check("rst_valid", {79'd0, instr_valid}, 80'd0);
        check("rst_busy",  {79'd0, busy}, 80'd0);
        check("rst_adr",   {79'd0, ADR}, 80'd0);

        // Full fetch, ack tied high.
        launch(64'd0);
        check("t1_busy", {79'd0, busy}, 80'd1);
        wait_valid(n);
        check("t1_lat", 80'(n), 80'd10);
        check("t1_instr", Instruction, 80'h30F20A00000000000000);

        // start alone in DONE is ignored.
        @(negedge Clk);
        start = 1'b1;
        PC = 64'd500;
        @(posedge Clk);
        #1;
        start = 1'b0;
        check("done_hold_valid", {79'd0, instr_valid}, 80'd1);
        check("done_hold_req", {79'd0, bus.mem_req}, 80'd0);
        check("done_hold_instr", Instruction, 80'h30F20A00000000000000);
        consume_it();

        // Slow memory: 3 wait cycles per byte.
        ack_delay = 3;
        launch(64'd0);
        wait_valid(n);
        check("t2_lat", 80'(n), 80'd40);
        check("t2_instr", Instruction, 80'h30F20A00000000000000);
        ack_delay = 0;
        consume_it();

        // Fetch running off the end of memory.
        launch(64'd1020);
`ifdef LEN_DECODE_EN
        repeat (4) @(posedge Clk);
        #1;
        check("t4_adr", {79'd0, ADR}, 80'd1);
        check("t4_valid", {79'd0, instr_valid}, 80'd0);
        check("t4_reads", 80'(addr_log.size()), 80'd4);
        do_reset();
        launch(64'd500);
        wait_valid(n);
        check("t5_lat", 80'(n), 80'd1);
        check("t5_reads", 80'(addr_log.size()), 80'd1);
        check("t5_instr", Instruction, 80'h90000000000000000000);
`else
        wait_valid(n);
        check("t4_lat", 80'(n), 80'd4);
        check("t4_reads", 80'(addr_log.size()), 80'd4);
        check("t4_first", {16'd0, addr_log[0]}, 80'd1020);
        check("t4_last", {16'd0, addr_log[addr_log.size() - 1]}, 80'd1023);
        check("t4_instr", Instruction, 80'h11223344000000000000);
        check("t4_adr", {79'd0, ADR}, 80'd0);
`endif

        // Back-to-back: consume with start in DONE.
        @(negedge Clk);
        addr_log.delete();
        consume = 1'b1;
        start = 1'b1;
        PC = 64'd0;
        @(posedge Clk);
        #1;
        consume = 1'b0;
        start = 1'b0;
        check("b2b_req", {79'd0, bus.mem_req}, 80'd1);
        check("b2b_valid", {79'd0, instr_valid}, 80'd0);
        check("b2b_addr", {16'd0, bus.mem_addr}, 80'd0);
        wait_valid(n);
        check("b2b_lat", 80'(n), 80'd10);
        check("b2b_instr", Instruction, 80'h30F20A00000000000000);
        consume_it();

        // Reset aborts a fetch after 5 bytes; later acks are ignored.
        launch(64'd0);
        repeat (5) @(posedge Clk);
        #1;
        check("t6_busy", {79'd0, busy}, 80'd1);
        @(negedge Clk);
        Rst = 1'b1;
        ack_force = 1'b1;
        @(posedge Clk);
        #1;
        check("t6_req",   {79'd0, bus.mem_req}, 80'd0);
        check("t6_addr",  {16'd0, bus.mem_addr}, 80'd0);
        check("t6_instr", Instruction, 80'd0);
        check("t6_valid", {79'd0, instr_valid}, 80'd0);
        check("t6_busy0", {79'd0, busy}, 80'd0);
        check("t6_adr",   {79'd0, ADR}, 80'd0);
        @(negedge Clk);
        Rst = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("t6_post_instr", Instruction, 80'd0);
        check("t6_post_busy", {79'd0, busy}, 80'd0);
        @(negedge Clk);
        ack_force = 1'b0;

        // PC beyond memory: ADR, no request, sticky until reset.
        req_cycles = 0;
        launch(64'd1024);
        check("t3_adr", {79'd0, ADR}, 80'd1);
        check("t3_req", {79'd0, bus.mem_req}, 80'd0);
        launch(64'd0);
        repeat (4) @(posedge Clk);
        #1;
        check("t3_sticky", {79'd0, ADR}, 80'd1);
        check("t3_noreq", 80'(req_cycles), 80'd0);
        do_reset();
        #1;
        check("t3_cleared", {79'd0, ADR}, 80'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
